cdb_arbiter: RTL and testbench

Parametrised common-data-bus arbiter for the Tomasulo back end. It collects completed results from NUM_CH execution units, for example ALU, AGU/load, MUL and DIV, through per-channel buffers. It grants one result per cycle onto a registered CDB broadcast. Optionally, branch results take priority, and a flush drops all pending results. Its outputs drive the `cdb_if` seen by the front-end cluster and the reservation stations.

---
 rtl/cdb_pkg.sv | 16 +
 rtl/cdb_if.sv | 35 +++
 rtl/cdb_chan_fifo.sv | 55 +++++
 rtl/cdb_arbiter.sv | 101 ++++++++++
 tb/tb_cdb_arbiter.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/cdb_pkg.sv
// Shared types and widths for the common-data-bus arbiter and its producers.
package cdb_pkg;

    localparam int unsigned CDB_DATA_W = 32;
    localparam int unsigned CDB_TAG_W  = 6;

    typedef struct packed {
        logic [CDB_DATA_W-1:0] data;
        logic [CDB_TAG_W-1:0]  tag;
        logic                  branch;
        logic                  branch_taken;
        logic                  store_pc;
        logic                  jalr;
    } cdb_entry_t;

endpackage

// File: rtl/cdb_if.sv
// Producer-side channels plus the registered CDB broadcast, bundled for the arbiter.
interface cdb_if
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_CH = 4
) ();

    localparam int unsigned SRC_W = $clog2(NUM_CH);

    logic [NUM_CH-1:0]             ch_valid;
    logic [NUM_CH-1:0]             ch_ready;
    cdb_entry_t [NUM_CH-1:0]       ch_entry;

    logic                          cdb_valid;
    logic [CDB_DATA_W-1:0]         cdb_data;
    logic [CDB_TAG_W-1:0]          cdb_tag;
    logic                          cdb_branch;
    logic                          cdb_branch_taken;
    logic                          cdb_store_pc;
    logic                          cdb_jalr;
    logic [SRC_W-1:0]              cdb_src;

    modport master (
        output ch_valid, ch_entry,
        input  ch_ready, cdb_valid, cdb_data, cdb_tag, cdb_branch,
               cdb_branch_taken, cdb_store_pc, cdb_jalr, cdb_src
    );

    modport slave (
        input  ch_valid, ch_entry,
        output ch_ready, cdb_valid, cdb_data, cdb_tag, cdb_branch,
               cdb_branch_taken, cdb_store_pc, cdb_jalr, cdb_src
    );

endinterface

// File: rtl/cdb_chan_fifo.sv
// Per-producer result buffer: small circular FIFO with flush; pushes when full are ignored.
module cdb_chan_fifo
    import cdb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       push,
    input  cdb_entry_t entry_in,
    input  logic       pop,
    output cdb_entry_t head,
    output logic       empty,
    output logic       full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    cdb_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign head    = mem[rd_ptr];

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= entry_in;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers per-channel results, grants one per cycle
// (branches first when enabled, otherwise round-robin) onto a registered broadcast.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned BRANCH_FIRST = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic flush,
    cdb_if.slave bus
);

    localparam int unsigned SRC_W = $clog2(NUM_CH);

    cdb_entry_t        head [NUM_CH];
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] ready;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic [NUM_CH-1:0] cand;
    logic [NUM_CH-1:0] br_cand;
    logic [NUM_CH-1:0] sel;
    logic [SRC_W:0]    sum;
    logic [SRC_W-1:0]  rr_ptr;
    logic [SRC_W-1:0]  grant_idx;
    logic              grant_valid;

    cdb_entry_t        out_entry;
    logic              out_valid;
    logic [SRC_W-1:0]  out_src;

    // Readiness comes only from registered occupancy, never from this cycle's pop.
    assign ready        = ~full & {NUM_CH{~rst}};
    assign bus.ch_ready = ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign push[k]    = bus.ch_valid[k] && ready[k] && !flush;
        assign pop[k]     = grant_valid && (grant_idx == SRC_W'(k));
        assign cand[k]    = !empty[k];
        assign br_cand[k] = !empty[k] && head[k].branch;

        cdb_chan_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .push     (push[k]),
            .entry_in (bus.ch_entry[k]),
            .pop      (pop[k]),
            .head     (head[k]),
            .empty    (empty[k]),
            .full     (full[k])
        );
    end

    // Circular first-match search starting at rr_ptr over the selected candidate set.
    always_comb begin
        sel         = ((BRANCH_FIRST != 0) && (|br_cand)) ? br_cand : cand;
        sum         = '0;
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, rr_ptr} + (SRC_W+1)'(i);
            if (sum >= (SRC_W+1)'(NUM_CH)) sum = sum - (SRC_W+1)'(NUM_CH);
            if (!grant_valid && sel[sum[SRC_W-1:0]]) begin
                grant_valid = 1'b1;
                grant_idx   = sum[SRC_W-1:0];
            end
        end
        if (flush) grant_valid = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_entry <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
        end else begin
            out_valid <= grant_valid;
            if (grant_valid) begin
                out_entry <= head[grant_idx];
                out_src   <= grant_idx;
                rr_ptr    <= (grant_idx == SRC_W'(NUM_CH - 1)) ? '0 : grant_idx + SRC_W'(1);
            end
        end
    end

    assign bus.cdb_valid        = out_valid;
    assign bus.cdb_data         = out_entry.data;
    assign bus.cdb_tag          = out_entry.tag;
    assign bus.cdb_branch       = out_entry.branch;
    assign bus.cdb_branch_taken = out_entry.branch_taken;
    assign bus.cdb_store_pc     = out_entry.store_pc;
    assign bus.cdb_jalr         = out_entry.jalr;
    assign bus.cdb_src          = out_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed-vector bench for cdb_arbiter (NUM_CH=4, DEPTH=2, BRANCH_FIRST=1).
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int unsigned NCH = 4;

    logic clk;
    logic rst;
    logic flush;
    int   tests = 0;
    int   fails = 0;

    cdb_if #(.NUM_CH(NCH)) bus ();

    cdb_arbiter #(.NUM_CH(NCH), .DEPTH(2), .BRANCH_FIRST(1)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            rst;
        logic            flush;
        logic [3:0]      valid;
        logic [3:0]      br;
        logic [3:0][5:0] tag;
        logic            ev;
        logic [1:0]      es;
        logic [5:0]      et;
        logic            eb;
        logic [3:0]      erdy;
    } vec_t;

    vec_t tbl [$];

    // Stimulus encoding: data = tag*4, store_pc = tag[0], jalr = tag[1], taken = branch.
    function automatic cdb_entry_t mk_entry(input logic [5:0] tag, input logic br);
        cdb_entry_t e;
        e.data         = {24'h0, tag, 2'b00};
        e.tag          = tag;
        e.branch       = br;
        e.branch_taken = br;
        e.store_pc     = tag[0];
        e.jalr         = tag[1];
        return e;
    endfunction

    function automatic vec_t mk(input logic r, input logic f, input logic [3:0] val,
                                input logic [3:0] br, input logic [5:0] t0, input logic [5:0] t1,
                                input logic [5:0] t2, input logic [5:0] t3, input logic ev,
                                input logic [1:0] es, input logic [5:0] et, input logic eb,
                                input logic [3:0] erdy);
        vec_t v;
        v.rst = r; v.flush = f; v.valid = val; v.br = br;
        v.tag[0] = t0; v.tag[1] = t1; v.tag[2] = t2; v.tag[3] = t3;
        v.ev = ev; v.es = es; v.et = et; v.eb = eb; v.erdy = erdy;
        return v;
    endfunction

    function automatic vec_t idle(input logic ev, input logic [1:0] es, input logic [5:0] et,
                                  input logic eb, input logic [3:0] erdy);
        return mk(1'b0, 1'b0, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, ev, es, et, eb, erdy);
    endfunction

    function automatic vec_t rst_vec();
        return mk(1'b1, 1'b0, 4'h0, 4'h0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, 4'b0000);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run(input string id, input vec_t v);
        rst          = v.rst;
        flush        = v.flush;
        bus.ch_valid = v.valid;
        for (int k = 0; k < 4; k++) bus.ch_entry[k] = mk_entry(v.tag[k], v.br[k]);
        @(posedge clk);
        #1;
        check({id, " valid"}, 32'(bus.cdb_valid), 32'(v.ev));
        check({id, " ready"}, 32'(bus.ch_ready), 32'(v.erdy));
        if (v.ev) begin
            check({id, " src"},      32'(bus.cdb_src),          32'(v.es));
            check({id, " tag"},      32'(bus.cdb_tag),          32'(v.et));
            check({id, " data"},     bus.cdb_data,              {24'h0, v.et, 2'b00});
            check({id, " branch"},   32'(bus.cdb_branch),       32'(v.eb));
            check({id, " taken"},    32'(bus.cdb_branch_taken), 32'(v.eb));
            check({id, " store_pc"}, 32'(bus.cdb_store_pc),     32'(v.et[0]));
            check({id, " jalr"},     32'(bus.cdb_jalr),         32'(v.et[1]));
        end
        if (v.rst) begin
            check({id, " rst data"}, bus.cdb_data, 32'h0);
            check({id, " rst tag"},  32'(bus.cdb_tag), 32'h0);
            check({id, " rst src"},  32'(bus.cdb_src), 32'h0);
            check({id, " rst flags"},
                  32'({bus.cdb_branch, bus.cdb_branch_taken, bus.cdb_store_pc, bus.cdb_jalr}), 32'h0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        flush        = 1'b0;
        bus.ch_valid = '0;
        bus.ch_entry = '0;

        // Single push on ch1, then round-robin, then branch priority.
        tbl.push_back(rst_vec());
        tbl.push_back(idle(1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0010, 4'b0000, 6'd0, 6'd9, 6'd0, 6'd0,
                         1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        tbl.push_back(idle(1'b1, 2'd1, 6'd9, 1'b0, 4'b1111));
        tbl.push_back(idle(1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        tbl.push_back(rst_vec());
        tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 6'h10, 6'h11, 6'h12, 6'h13,
                         1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        for (int i = 0; i < 7; i++)
            tbl.push_back(mk(1'b0, 1'b0, 4'b1111, 4'b0000, 6'h10, 6'h11, 6'h12, 6'h13,
                             1'b1, 2'(i % 4), 6'(16 + i % 4), 1'b0, 4'(1 << (i % 4))));
        tbl.push_back(rst_vec());
        tbl.push_back(mk(1'b0, 1'b0, 4'b1011, 4'b1000, 6'd1, 6'd2, 6'd0, 6'd21,
                         1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        tbl.push_back(idle(1'b1, 2'd3, 6'd21, 1'b1, 4'b1111));
        tbl.push_back(idle(1'b1, 2'd0, 6'd1,  1'b0, 4'b1111));
        tbl.push_back(idle(1'b1, 2'd1, 6'd2,  1'b0, 4'b1111));
        tbl.push_back(mk(1'b0, 1'b0, 4'b0111, 4'b0011, 6'd30, 6'd31, 6'd32, 6'd0,
                         1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        tbl.push_back(idle(1'b1, 2'd0, 6'd30, 1'b1, 4'b1111));
        tbl.push_back(idle(1'b1, 2'd1, 6'd31, 1'b1, 4'b1111));
        tbl.push_back(idle(1'b1, 2'd2, 6'd32, 1'b0, 4'b1111));
        tbl.push_back(idle(1'b0, 2'd0, 6'd0,  1'b0, 4'b1111));

        for (int i = 0; i < tbl.size(); i++) run($sformatf("t%0d", i), tbl[i]);

        // Backpressure: branches on ch0/ch1 starve ch2 while it fills; 3rd offer held off.
        run("bp1", mk(1'b0, 1'b0, 4'b0111, 4'b0011, 6'd40, 6'd41, 6'd50, 6'd0,
                      1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        run("bp2", mk(1'b0, 1'b0, 4'b0111, 4'b0011, 6'd42, 6'd43, 6'd51, 6'd0,
                      1'b1, 2'd0, 6'd40, 1'b1, 4'b1001));
        run("bp3", mk(1'b0, 1'b0, 4'b0101, 4'b0001, 6'd44, 6'd0, 6'd52, 6'd0,
                      1'b1, 2'd1, 6'd41, 1'b1, 4'b1010));
        run("bp4", mk(1'b0, 1'b0, 4'b0100, 4'b0000, 6'd0, 6'd0, 6'd52, 6'd0,
                      1'b1, 2'd0, 6'd42, 1'b1, 4'b1011));
        run("bp5", mk(1'b0, 1'b0, 4'b0100, 4'b0000, 6'd0, 6'd0, 6'd52, 6'd0,
                      1'b1, 2'd1, 6'd43, 1'b1, 4'b1011));
        run("bp6", mk(1'b0, 1'b0, 4'b0100, 4'b0000, 6'd0, 6'd0, 6'd52, 6'd0,
                      1'b1, 2'd0, 6'd44, 1'b1, 4'b1011));
        run("bp7", mk(1'b0, 1'b0, 4'b0100, 4'b0000, 6'd0, 6'd0, 6'd52, 6'd0,
                      1'b1, 2'd2, 6'd50, 1'b0, 4'b1111));
        run("bp8", mk(1'b0, 1'b0, 4'b0100, 4'b0000, 6'd0, 6'd0, 6'd52, 6'd0,
                      1'b1, 2'd2, 6'd51, 1'b0, 4'b1111));
        run("bp9",  idle(1'b1, 2'd2, 6'd52, 1'b0, 4'b1111));
        run("bp10", idle(1'b0, 2'd0, 6'd0,  1'b0, 4'b1111));

        // Flush with three queued entries and one broadcast in flight.
        run("fl1", mk(1'b0, 1'b0, 4'b1111, 4'b0000, 6'd60, 6'd61, 6'd62, 6'd63,
                      1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        run("fl2", idle(1'b1, 2'd3, 6'd63, 1'b0, 4'b1111));
        run("fl3", mk(1'b0, 1'b1, 4'b0001, 4'b0000, 6'd59, 6'd0, 6'd0, 6'd0,
                      1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        for (int j = 0; j < 4; j++)
            run($sformatf("fl_quiet%0d", j), idle(1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        run("fl8", mk(1'b0, 1'b0, 4'b0010, 4'b0000, 6'd0, 6'd58, 6'd0, 6'd0,
                      1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        run("fl9",  idle(1'b1, 2'd1, 6'd58, 1'b0, 4'b1111));
        run("fl10", idle(1'b0, 2'd0, 6'd0,  1'b0, 4'b1111));

        // Mid-run reset with non-empty buffers.
        run("mr1", mk(1'b0, 1'b0, 4'b1111, 4'b0000, 6'd20, 6'd21, 6'd22, 6'd23,
                      1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        run("mr2", mk(1'b0, 1'b0, 4'b1111, 4'b0000, 6'd24, 6'd25, 6'd26, 6'd27,
                      1'b1, 2'd2, 6'd22, 1'b0, 4'b0100));
        run("mr3", rst_vec());
        run("mr4", idle(1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        run("mr5", mk(1'b0, 1'b0, 4'b1000, 4'b0000, 6'd0, 6'd0, 6'd0, 6'd28,
                      1'b0, 2'd0, 6'd0, 1'b0, 4'b1111));
        run("mr6", idle(1'b1, 2'd3, 6'd28, 1'b0, 4'b1111));
        run("mr7", idle(1'b0, 2'd0, 6'd0,  1'b0, 4'b1111));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
